// File: rtl/axis_latency_pkg.sv
// Shared types and constants for the AXI-Stream latency meter.
// Averaging build is selected with AXIS_LATENCY_METER_AVG_EN.
package axis_latency_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COUNTING,
    ST_DONE,
    ST_TIMEOUT
  } meter_state_e;

  localparam int AVG_COUNT         = 4;
  localparam int AVG_SHIFT         = 2;
  localparam int DEFAULT_MAX_DELAY = 63;
  localparam int DELAY_W           = 6;

  // Rounded mean of AVG_COUNT results: (sum + AVG_COUNT/2) / AVG_COUNT.
  function automatic logic [7:0] avg_round(input logic [7:0] sum);
    logic [8:0] wide;
    wide = 9'(sum) + 9'(AVG_COUNT / 2);
    return 8'(wide >> AVG_SHIFT);
  endfunction

endpackage

// File: rtl/axis_pattern_match.sv
// Masked marker compare on one tapped stream; purely combinational.
module axis_pattern_match #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic [TDATA_WIDTH-1:0] tdata,
  input  logic                   beat,
  input  logic [TDATA_WIDTH-1:0] pattern,
  input  logic [TDATA_WIDTH-1:0] pattern_mask,
  output logic                   match
);

  assign match = beat && (((tdata ^ pattern) & pattern_mask) == '0);

endmodule

// File: rtl/axis_latency_meter.sv
// Measures the beat delay between a marker on the REF tap and its return on the DUT tap.
// Define AXIS_LATENCY_METER_AVG_EN to average AVG_COUNT back-to-back measurements per start.
module axis_latency_meter
  import axis_latency_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int MAX_DELAY   = DEFAULT_MAX_DELAY
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] REF_TDATA,
  input  logic                   REF_BEAT,
  input  logic [TDATA_WIDTH-1:0] DUT_TDATA,
  input  logic                   DUT_BEAT,
  input  logic [TDATA_WIDTH-1:0] pattern,
  input  logic [TDATA_WIDTH-1:0] pattern_mask,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [DELAY_W-1:0]     delay_out
);

  // One extra bit so counter + REF_BEAT can exceed MAX_DELAY without wrapping.
  localparam int CNT_W = $clog2(MAX_DELAY + 1) + 1;

  logic [1:0]   rst_sync;
  logic         rst_int_n;

  meter_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
  logic         done_q, done_d;
  logic         timeout_q, timeout_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  logic         ref_match, dut_match;
  logic         meas_fin;
  logic [CNT_W-1:0] meas_val;

`ifdef AXIS_LATENCY_METER_AVG_EN
  localparam int IDX_W = $clog2(AVG_COUNT);
  logic [7:0]       acc_q, acc_d, acc_sum;
  logic [IDX_W-1:0] idx_q, idx_d;
`endif

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync[1];

  axis_pattern_match #(.TDATA_WIDTH(TDATA_WIDTH)) u_ref_match (
    .tdata        (REF_TDATA),
    .beat         (REF_BEAT),
    .pattern      (pattern),
    .pattern_mask (pattern_mask),
    .match        (ref_match)
  );

  axis_pattern_match #(.TDATA_WIDTH(TDATA_WIDTH)) u_dut_match (
    .tdata        (DUT_TDATA),
    .beat         (DUT_BEAT),
    .pattern      (pattern),
    .pattern_mask (pattern_mask),
    .match        (dut_match)
  );

  assign cnt_step = cnt_q + CNT_W'(REF_BEAT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    delay_d   = delay_q;
    meas_fin  = 1'b0;
    meas_val  = '0;
`ifdef AXIS_LATENCY_METER_AVG_EN
    acc_d     = acc_q;
    idx_d     = idx_q;
    acc_sum   = '0;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d   = ST_ARMED;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          delay_d   = '0;
`ifdef AXIS_LATENCY_METER_AVG_EN
          acc_d     = '0;
          idx_d     = '0;
`endif
        end
      end
      ST_ARMED: begin
        if (ref_match) begin
          if (dut_match) begin
            meas_fin = 1'b1;
          end else begin
            state_d = ST_COUNTING;
            cnt_d   = '0;
          end
        end
      end
      ST_COUNTING: begin
        // A returning marker beats the timeout when both land on the same beat.
        if (dut_match) begin
          meas_fin = 1'b1;
          meas_val = (cnt_step > CNT_W'(MAX_DELAY)) ? CNT_W'(MAX_DELAY) : cnt_step;
        end else if (cnt_step > CNT_W'(MAX_DELAY)) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          delay_d   = DELAY_W'(MAX_DELAY);
        end else begin
          cnt_d = cnt_step;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (meas_fin) begin
`ifdef AXIS_LATENCY_METER_AVG_EN
      acc_sum = acc_q + 8'(meas_val);
      if (idx_q == IDX_W'(AVG_COUNT - 1)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        delay_d = DELAY_W'(avg_round(acc_sum));
      end else begin
        state_d = ST_ARMED;
        cnt_d   = '0;
        acc_d   = acc_sum;
        idx_d   = idx_q + IDX_W'(1);
      end
`else
      state_d = ST_DONE;
      done_d  = 1'b1;
      delay_d = DELAY_W'(meas_val);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      delay_q   <= '0;
`ifdef AXIS_LATENCY_METER_AVG_EN
      acc_q     <= '0;
      idx_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      delay_q   <= delay_d;
`ifdef AXIS_LATENCY_METER_AVG_EN
      acc_q     <= acc_d;
      idx_q     <= idx_d;
`endif
    end
  end

  assign busy      = (state_q == ST_ARMED) || (state_q == ST_COUNTING);
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign delay_out = delay_q;

endmodule

// File: tb/tb_axis_latency_meter.sv
// Directed scoreboard bench for axis_latency_meter; results checked by a negedge monitor.
// Runs the averaging scenario instead of the single-shot ones when AXIS_LATENCY_METER_AVG_EN is defined.
module tb_axis_latency_meter;

  localparam int W = 32;
  localparam logic [W-1:0] MARK = 32'hA5A5A5A5;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] ref_tdata = '0;
  logic         ref_beat = 1'b0;
  logic [W-1:0] dut_tdata = '0;
  logic         dut_beat = 1'b0;
  logic [W-1:0] pattern = MARK;
  logic [W-1:0] pattern_mask = '1;
  logic         start = 1'b0;
  logic         busy, done, timeout;
  logic [5:0]   delay_out;

  axis_latency_meter #(.TDATA_WIDTH(W), .MAX_DELAY(63)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .REF_TDATA    (ref_tdata),
    .REF_BEAT     (ref_beat),
    .DUT_TDATA    (dut_tdata),
    .DUT_BEAT     (dut_beat),
    .pattern      (pattern),
    .pattern_mask (pattern_mask),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .delay_out    (delay_out)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected {timeout, done, delay_out} and the cycle it must appear in
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         both_seen = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_to = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    int ec;
    if (done && timeout) both_seen = 1'b1;
    if ((done && !prev_done) || (timeout && !prev_to)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: actual to=%0b done=%0b delay=%0d at cycle %0d, required no result",
                 timeout, done, delay_out, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({timeout, done, delay_out} !== e || cyc != ec) begin
          failures++;
          $display("FAIL result: actual to=%0b done=%0b delay=%0d cycle=%0d, required to=%0b done=%0b delay=%0d cycle=%0d",
                   timeout, done, delay_out, cyc, e[7], e[6], e[5:0], ec);
        end
      end
    end
    prev_done = done;
    prev_to   = timeout;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_delay"}, 32'(delay_out), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    ref_beat = 1'b0;
    dut_beat = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Both taps beat every cycle; REF marker at beat 1, DUT tap is REF delayed by d beats
  // (d < 0: DUT never carries the marker). A gap of beat-less cycles carrying the marker
  // value is inserted before beat gap_after.
  task automatic run_stream(input int d, input int n_beats, input int gap_after,
                            input int gap_len, input int start_at,
                            input bit push, input logic [7:0] exp_v);
    logic [W-1:0] hist[$];
    logic [W-1:0] rd, dd;
    int dec_idx;
    dec_idx = (d < 0) ? 65 : 1 + d;
    if (push) begin
      exp_q.push_back(exp_v);
      exp_cyc_q.push_back(cyc + dec_idx + ((dec_idx >= gap_after) ? gap_len : 0) + 1);
    end
    for (int i = 0; i < n_beats; i++) begin
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          ref_tdata = MARK;
          dut_tdata = MARK;
          ref_beat  = 1'b0;
          dut_beat  = 1'b0;
          tick();
        end
      end
      rd = (i == 1) ? MARK : 32'h1000_0000 + 32'(i);
      hist.push_back(rd);
      if (d < 0)       dd = 32'h3000_0000 + 32'(i);
      else if (i >= d) dd = hist[i - d];
      else             dd = 32'h2000_0000 + 32'(i);
      start     = (i == start_at);
      ref_beat  = 1'b1;
      dut_beat  = 1'b1;
      ref_tdata = rd;
      dut_tdata = dd;
      tick();
    end
    start    = 1'b0;
    ref_beat = 1'b0;
    dut_beat = 1'b0;
  endtask

  task automatic finish_report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Stimulus
  initial begin
    #3 resetn = 1'b0;
    tick();
    tick();
    check_cleared("reset_state");
    resetn = 1'b1;
    repeat (3) tick();

`ifdef AXIS_LATENCY_METER_AVG_EN
    pulse_start();
    check("avg_busy_after_start", 32'(busy), 32'd1);
    run_stream(4, 8, 1000, 0, -1, 1'b0, 8'h00);
    run_stream(4, 8, 1000, 0, -1, 1'b0, 8'h00);
    run_stream(5, 9, 1000, 0, -1, 1'b0, 8'h00);
    run_stream(5, 9, 1000, 0, -1, 1'b1, {1'b0, 1'b1, 6'd5});
    repeat (3) tick();
    check("avg_hold_delay", 32'(delay_out), 32'd5);

    pulse_start();
    run_stream(-1, 68, 1000, 0, -1, 1'b1, {1'b1, 1'b0, 6'd63});
`else
    // Delay 5, continuous beats
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_done", 32'(done), 32'd0);
    run_stream(5, 12, 1000, 0, -1, 1'b1, {1'b0, 1'b1, 6'd5});
    repeat (3) tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_delay", 32'(delay_out), 32'd5);

    // Marker on both taps in the same beat
    pulse_start();
    run_stream(0, 6, 1000, 0, -1, 1'b1, {1'b0, 1'b1, 6'd0});

    // Marker never returns
    pulse_start();
    run_stream(-1, 68, 1000, 0, -1, 1'b1, {1'b1, 1'b0, 6'd63});

    // Delay 3 with a 10-cycle beat gap and a stray start while counting
    pulse_start();
    run_stream(3, 10, 3, 10, 2, 1'b1, {1'b0, 1'b1, 6'd3});

    // Reset in the middle of a measurement, then measure again
    pulse_start();
    run_stream(-1, 4, 1000, 0, -1, 1'b0, 8'h00);
    check("counting_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1 check_cleared("async_reset");
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    pulse_start();
    run_stream(2, 8, 1000, 0, -1, 1'b1, {1'b0, 1'b1, 6'd2});
`endif

    repeat (5) tick();
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("done_timeout_exclusive", 32'(both_seen), 32'd0);
    finish_report();
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_latency_meter.md
AXIS_LATENCY_METER -- requirements
Module: axis_latency_meter

Interface
REQ-001 Parameters SHALL be:
- TDATA_WIDTH, default 32, width of both tapped streams.
- MAX_DELAY, default 63, largest measurable delay in beats; this matches the 6-bit delay field of the stream delay block.
REQ-002 Ports SHALL be:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous active-low reset.
- REF_TDATA  in  TDATA_WIDTH  stream tap upstream of the delay under test.
- REF_BEAT  in  1  REF TVALID&TREADY.
- DUT_TDATA  in  TDATA_WIDTH  stream tap downstream of the delay under test.
- DUT_BEAT  in  1  DUT TVALID&TREADY.
- pattern  in  TDATA_WIDTH  marker value.
- pattern_mask  in  TDATA_WIDTH  1 = bit compared.
- start  in  1  one-cycle request to begin a measurement.
- busy  out  1  measurement in progress.
- done  out  1  result valid.
- timeout  out  1  no marker returned within MAX_DELAY.
- delay_out  out  6  measured delay in beats.

Function
REQ-003 A beat on a stream SHALL "match" when its BEAT=1 and ((TDATA ^ pattern) & pattern_mask) == 0; match is combinational.
REQ-004 The FSM SHALL have states IDLE, ARMED, COUNTING, DONE, TIMEOUT.
REQ-005 IDLE SHALL move to ARMED on start=1. The cycle start is seen SHALL clear done, timeout and the beat counter.
REQ-006 start SHALL be ignored in ARMED and COUNTING.
REQ-007 In DONE or TIMEOUT, start=1 SHALL move to ARMED, the same as from IDLE.
REQ-008 In ARMED, DUT matches SHALL be ignored unless the REF stream matches in the same cycle.
REQ-009 In ARMED, a REF match with a simultaneous DUT match SHALL give delay 0 and go to DONE. A REF match alone SHALL go to COUNTING with the counter at 0.
REQ-010 In COUNTING, each REF_BEAT SHALL increment the counter. Counter width SHALL be clog2(MAX_DELAY+1)+1 so that it never wraps.
REQ-011 In COUNTING, a DUT match SHALL set the result to counter + REF_BEAT (same-cycle REF beat included) and go to DONE.
REQ-012 In COUNTING, if counter + REF_BEAT exceeds MAX_DELAY with no DUT match, the FSM SHALL go to TIMEOUT with delay_out = MAX_DELAY.
REQ-013 If REQ-011 and REQ-012 hold in the same cycle, the DUT match SHALL win.
REQ-014 done, timeout and delay_out SHALL be registered. They SHALL update exactly one cycle after the deciding beat and hold until the next accepted start.
REQ-015 busy SHALL be 1 in ARMED and COUNTING only.
REQ-016 done and timeout SHALL never both be 1.
REQ-017 Cycles with BEAT=0 SHALL not advance any count, whatever the TDATA value.

Reset
REQ-018 resetn low SHALL force IDLE asynchronously and zero the counter, busy, done, timeout and delay_out, including mid-measurement.
REQ-019 Reset deassertion SHALL be synchronized to clk inside the block.

Configuration
REQ-020 With AXIS_LATENCY_METER_AVG_EN defined, one start SHALL run 4 back-to-back measurements, re-entering ARMED after each.
- Results SHALL be summed in an 8-bit accumulator.
- done SHALL assert only after the 4th measurement, with delay_out = (sum + 2) >> 2.
- Any timeout SHALL end the sequence in TIMEOUT with delay_out = MAX_DELAY.
REQ-021 Without the macro, one start SHALL run exactly one measurement and no accumulator SHALL be synthesized.

Structure
REQ-022 Package axis_latency_pkg SHALL hold the state enum, the averaging count (4) and the default MAX_DELAY.
REQ-023 The masked compare SHALL be one sub-module, axis_pattern_match, instantiated once for REF and once for DUT.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Delay block set to 5, continuous beats, marker 0xA5A5A5A5, mask all ones -> done=1, delay_out=5, one cycle after the DUT marker beat.
- Marker on both taps in the same beat -> done=1, delay_out=0.
- REF marker, DUT never matches, 64 REF beats -> timeout=1, delay_out=63, done=0.
- Delay 3 with REF_BEAT/DUT_BEAT gated off for 10 cycles mid-measurement -> delay_out=3.
- resetn pulsed low in COUNTING -> outputs 0 asynchronously; the next start measures correctly.
- AVG_EN build with delays 4, 4, 5, 5 -> delay_out=5 ((18+2)>>2), with a single done after the 4th measurement.
